// File: rtl/solution_receiver.sv
// Rebuilds a nonogram solution grid from a UART byte stream: a header {m,n}, then two bytes per row.
// Commits grid/m/n with a one-cycle done pulse; malformed or stalled frames give a one-cycle error pulse.

module solution_row #(
  parameter int MAX_COLS = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_lo,
  input  logic                wr_hi,
  input  logic [7:0]          data,
  input  logic [MAX_COLS-1:0] col_en,
  output logic [MAX_COLS-1:0] bits_nx
);
  logic [MAX_COLS-1:0] bits;

  // Columns 0-7 come from the low byte, 8.. from the high byte; padding columns are masked off.
  always_comb begin
    bits_nx = bits;
    if (clr) bits_nx = '0;
    else begin
      for (int c = 0; c < MAX_COLS; c++) begin
        if (wr_lo && c < 8)  bits_nx[c] = data[c % 8] & col_en[c];
        if (wr_hi && c >= 8) bits_nx[c] = data[c % 8] & col_en[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bits <= '0;
    else     bits <= bits_nx;
  end
endmodule

module solution_receiver #(
  parameter int MAX_ROWS       = 11,
  parameter int MAX_COLS       = 11,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [7:0]                   byte_in,
  output logic [MAX_ROWS*MAX_COLS-1:0] solution,
  output logic [$clog2(MAX_ROWS)-1:0]  m,
  output logic [$clog2(MAX_COLS)-1:0]  n,
  output logic                         done,
  output logic                         error
);
  localparam int MW = $clog2(MAX_ROWS);
  localparam int NW = $clog2(MAX_COLS);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    MAX_M   = 5'(MAX_ROWS);
  localparam logic [4:0]    MAX_N   = 5'(MAX_COLS);

  typedef enum logic [1:0] {IDLE, ROW_LO, ROW_HI} state_t;
  typedef struct packed {
    logic [3:0] m;
    logic [3:0] n;
  } hdr_t;

  state_t state, state_nx;
  hdr_t   hdr_in, shadow;
  logic [3:0]    row_idx;
  logic [GW-1:0] gap_cnt;

  logic        hdr_ok, pad_bad, last_row, gap_hit;
  logic        start, wr_lo, wr_hi, commit, reject;
  logic [15:0] col_en;
  logic [MAX_COLS-1:0] col_en_row;
  logic [MAX_ROWS-1:0] wr_lo_r, wr_hi_r;
  logic [MAX_ROWS-1:0][MAX_COLS-1:0] rows_nx;

  assign hdr_in = hdr_t'(byte_in);

  always_comb begin
    hdr_ok = (hdr_in.m != 4'd0) && ({1'b0, hdr_in.m} <= MAX_M) &&
             (hdr_in.n != 4'd0) && ({1'b0, hdr_in.n} <= MAX_N);
    for (int c = 0; c < 16; c++) col_en[c] = (5'(c) < {1'b0, shadow.n});
    pad_bad  = (state == ROW_LO) ? |(byte_in & ~col_en[7:0]) : |(byte_in & ~col_en[15:8]);
    last_row = (row_idx == (shadow.m - 4'd1));
    gap_hit  = (gap_cnt == GAP_MAX);
  end

  assign col_en_row = col_en[MAX_COLS-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: an arriving byte always wins over the timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (valid_in && hdr_ok) state_nx = ROW_LO;
      ROW_LO: if (valid_in)           state_nx = pad_bad ? IDLE : ROW_HI;
              else if (gap_hit)       state_nx = IDLE;
      ROW_HI: if (valid_in)           state_nx = (pad_bad || last_row) ? IDLE : ROW_LO;
              else if (gap_hit)       state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Control strobes
  always_comb begin
    start  = 1'b0;
    wr_lo  = 1'b0;
    wr_hi  = 1'b0;
    commit = 1'b0;
    reject = 1'b0;
    case (state)
      IDLE:   if (valid_in) begin
                if (hdr_ok) start  = 1'b1;
                else        reject = 1'b1;
              end
      ROW_LO: if (valid_in) begin
                if (pad_bad) reject = 1'b1;
                else         wr_lo  = 1'b1;
              end else if (gap_hit) reject = 1'b1;
      ROW_HI: if (valid_in) begin
                if (pad_bad) reject = 1'b1;
                else begin
                  wr_hi  = 1'b1;
                  commit = last_row;
                end
              end else if (gap_hit) reject = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    for (int r = 0; r < MAX_ROWS; r++) begin
      wr_lo_r[r] = wr_lo && (row_idx == 4'(r));
      wr_hi_r[r] = wr_hi && (row_idx == 4'(r));
    end
  end

  solution_row #(.MAX_COLS(MAX_COLS)) u_row [MAX_ROWS-1:0] (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .wr_lo   (wr_lo_r),
    .wr_hi   (wr_hi_r),
    .data    (byte_in),
    .col_en  (col_en_row),
    .bits_nx (rows_nx)
  );

  // Commit takes the next-state rows so the final high byte lands in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      row_idx  <= '0;
      gap_cnt  <= '0;
      solution <= '0;
      m        <= '0;
      n        <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done  <= commit;
      error <= reject;
      if (start) begin
        shadow  <= hdr_in;
        row_idx <= '0;
      end else if (wr_hi && !commit) begin
        row_idx <= row_idx + 4'd1;
      end
      gap_cnt <= (state == IDLE || valid_in || gap_hit) ? '0 : gap_cnt + 1'b1;
      if (commit) begin
        solution <= rows_nx;
        m        <= MW'(shadow.m);
        n        <= NW'(shadow.n);
      end
    end
  end
endmodule
